// File: rtl/uart_tx_fifo_framer_if.sv
// Bus-side and pad-side signal bundle for uart_tx_fifo_framer.
// The send_break signal exists only when UART_TX_BREAK_EN is defined.
interface uart_tx_fifo_framer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  parity_enable;
  logic                  parity_type;
  logic                  two_stop_bits;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] parallel_data;
  logic                  ready;
  logic                  serial_data_out;
  logic                  busy;
  logic [CNT_W-1:0]      fifo_count;
`ifdef UART_TX_BREAK_EN
  logic                  send_break;
`endif

  modport master (
    output baud_div, parity_enable, parity_type, two_stop_bits, data_valid, parallel_data,
`ifdef UART_TX_BREAK_EN
    output send_break,
`endif
    input  ready, serial_data_out, busy, fifo_count
  );

  modport slave (
    input  baud_div, parity_enable, parity_type, two_stop_bits, data_valid, parallel_data,
`ifdef UART_TX_BREAK_EN
    input  send_break,
`endif
    output ready, serial_data_out, busy, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo_framer.sv
// FIFO-buffered UART transmitter with baud divider, optional parity and 1/2 stop bits.
// Optional line-break support is compiled in with UART_TX_BREAK_EN.
module uart_tx_fifo_framer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input logic                  clk,
  input logic                  reset,
  uart_tx_fifo_framer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d, div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d, head;
  logic                  par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic                  line_q, line_d, busy_q, busy_d;
  logic                  push, pop, baud_tick, hold, brk_next;

  assign bus.ready           = (count_q != CNT_W'(FIFO_DEPTH));
  assign bus.serial_data_out = line_q;
  assign bus.busy            = busy_q;
  assign bus.fifo_count      = count_q;

  assign push      = bus.data_valid && bus.ready;
  assign head      = mem_q[rd_ptr_q];
  assign baud_tick = (baud_cnt_q == div_q);

  // Break holds off popping while requested and for one edge after release.
`ifdef UART_TX_BREAK_EN
  logic brk_q;
  assign brk_next = (state_q == IDLE) && bus.send_break;
  assign hold     = bus.send_break || brk_q;

  always_ff @(posedge clk) begin
    if (!reset) brk_q <= 1'b0;
    else        brk_q <= brk_next;
  end
`else
  assign brk_next = 1'b0;
  assign hold     = 1'b0;
`endif

  // FIFO next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.parallel_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Framer FSM next state and registered line/busy values
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    idx_d      = idx_q;
    word_d     = word_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    pop        = 1'b0;

    if (state_q == IDLE) begin
      baud_cnt_d = '0;
      if (count_q != '0 && !hold) begin
        pop        = 1'b1;
        word_d     = head;
        par_en_d   = bus.parity_enable;
        par_bit_d  = bus.parity_type ? ~^head : ^head;
        two_stop_d = bus.two_stop_bits;
        div_d      = bus.baud_div;
        idx_d      = '0;
        state_d    = START;
      end
    end else if (!baud_tick) begin
      baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
    end else begin
      baud_cnt_d = '0;
      unique case (state_q)
        START: begin
          state_d = DATA;
          idx_d   = '0;
        end
        DATA: begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d   = '0;
            state_d = par_en_q ? PARITY : STOP1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        PARITY:  state_d = STOP1;
        STOP1:   state_d = two_stop_q ? STOP2 : IDLE;
        default: state_d = IDLE;
      endcase
    end

    unique case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = word_d[idx_d];
      PARITY:  line_d = par_bit_d;
      default: line_d = 1'b1;
    endcase
    if (brk_next) line_d = 1'b0;
    busy_d = (state_d != IDLE) || brk_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      line_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_framer.sv
// Directed self-checking bench for uart_tx_fifo_framer (8 data bits, 4-entry FIFO).
// Frame vectors list line values in transmit order, bit 0 = start bit.
module tb_uart_tx_fifo_framer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_framer_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) bus ();

  uart_tx_fifo_framer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    bus.data_valid    = 1'b1;
    bus.parallel_data = w;
    tick();
    bus.data_valid    = 1'b0;
  endtask

  // Called at the sample point 'skip' clocks after the popping edge.
  task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits,
                             input int div, input int skip);
    for (int k = skip; k < nbits * (div + 1); k++) begin
      check({tag, "_line"}, 32'(bus.serial_data_out), 32'(bits[k / (div + 1)]));
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      tick();
    end
    check({tag, "_idle_line"}, 32'(bus.serial_data_out), 32'd1);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.baud_div      = 16'd3;
    bus.parity_enable = 1'b0;
    bus.parity_type   = 1'b0;
    bus.two_stop_bits = 1'b0;
    bus.data_valid    = 1'b0;
    bus.parallel_data = 8'h00;
`ifdef UART_TX_BREAK_EN
    bus.send_break    = 1'b0;
`endif
    tick();
    tick();
    check("rst_line",  32'(bus.serial_data_out), 32'd1);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    reset = 1'b1;
    tick();

    // 0xA5, no parity, one stop bit, 4 clocks per bit
    push_word(8'hA5);
    check("t1_count_after_push", 32'(bus.fifo_count), 32'd1);
    check("t1_busy_before_pop",  32'(bus.busy), 32'd0);
    tick();
    check("t1_count_after_pop", 32'(bus.fifo_count), 32'd0);
    check_frame("t1", {1'b1, 8'hA5, 1'b0}, 10, 3, 0);

    // even parity (bit 0), two stop bits: 48 clocks
    bus.parity_enable = 1'b1;
    bus.parity_type   = 1'b0;
    bus.two_stop_bits = 1'b1;
    push_word(8'hA5);
    tick();
    check_frame("t2_even2", {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}, 12, 3, 0);

    // odd parity (bit 1), one stop bit
    bus.parity_type   = 1'b1;
    bus.two_stop_bits = 1'b0;
    push_word(8'hA5);
    tick();
    check_frame("t2_odd1", {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 3, 0);

    // FIFO fill with 6 pushes at baud_div=7; first word pops on 2nd push edge
    bus.parity_enable = 1'b0;
    bus.baud_div      = 16'd7;
    bus.data_valid    = 1'b1;
    bus.parallel_data = 8'h01;
    tick();
    check("t3_count_p1", 32'(bus.fifo_count), 32'd1);
    bus.parallel_data = 8'h02;
    tick();
    check("t3_count_p2", 32'(bus.fifo_count), 32'd1);
    bus.parallel_data = 8'h03;
    tick();
    bus.parallel_data = 8'h04;
    tick();
    check("t3_ready_p4", 32'(bus.ready), 32'd1);
    bus.parallel_data = 8'h05;
    tick();
    check("t3_ready_full", 32'(bus.ready), 32'd0);
    check("t3_count_full", 32'(bus.fifo_count), 32'd4);
    bus.parallel_data = 8'h06;
    tick();
    bus.data_valid = 1'b0;
    check("t3_count_drop", 32'(bus.fifo_count), 32'd4);
    check_frame("t3_w01", {1'b1, 8'h01, 1'b0}, 10, 7, 4);
    tick();
    check_frame("t3_w02", {1'b1, 8'h02, 1'b0}, 10, 7, 0);
    tick();
    check_frame("t3_w03", {1'b1, 8'h03, 1'b0}, 10, 7, 0);
    tick();
    check_frame("t3_w04", {1'b1, 8'h04, 1'b0}, 10, 7, 0);
    tick();
    check_frame("t3_w05", {1'b1, 8'h05, 1'b0}, 10, 7, 0);
    check("t3_count_empty", 32'(bus.fifo_count), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t3_no_w06_line", 32'(bus.serial_data_out), 32'd1);
      check("t3_no_w06_busy", 32'(bus.busy), 32'd0);
    end

    // baud_div change mid-frame affects only the next frame
    bus.baud_div = 16'd3;
    push_word(8'h3C);
    tick();
    bus.baud_div = 16'd1;
    push_word(8'hC3);
    check_frame("t4_old_div", {1'b1, 8'h3C, 1'b0}, 10, 3, 1);
    tick();
    check_frame("t4_new_div", {1'b1, 8'hC3, 1'b0}, 10, 1, 0);

    // reset during DATA bit 3 flushes FIFO and returns line high
    bus.baud_div = 16'd3;
    push_word(8'hA5);
    tick();
    push_word(8'h77);
    for (int i = 0; i < 16; i++) tick();
    check("t5_bit3_line", 32'(bus.serial_data_out), 32'd0);
    check("t5_count_pre", 32'(bus.fifo_count), 32'd1);
    reset = 1'b0;
    tick();
    check("t5_rst_line",  32'(bus.serial_data_out), 32'd1);
    check("t5_rst_busy",  32'(bus.busy), 32'd0);
    check("t5_rst_count", 32'(bus.fifo_count), 32'd0);
    check("t5_rst_ready", 32'(bus.ready), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("t5_post_line", 32'(bus.serial_data_out), 32'd1);
      check("t5_post_busy", 32'(bus.busy), 32'd0);
    end

`ifdef UART_TX_BREAK_EN
    // break requested during a frame starts after the frame; queued word follows release
    push_word(8'h3C);
    tick();
    bus.send_break = 1'b1;
    push_word(8'h81);
    check_frame("t6_frame", {1'b1, 8'h3C, 1'b0}, 10, 3, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_brk_line",  32'(bus.serial_data_out), 32'd0);
      check("t6_brk_busy",  32'(bus.busy), 32'd1);
      check("t6_brk_count", 32'(bus.fifo_count), 32'd1);
    end
    bus.send_break = 1'b0;
    tick();
    check("t6_rel_line",  32'(bus.serial_data_out), 32'd1);
    check("t6_rel_count", 32'(bus.fifo_count), 32'd1);
    tick();
    check_frame("t6_queued", {1'b1, 8'h81, 1'b0}, 10, 3, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_framer.md
Name: uart_tx_fifo_framer

Overview:
Parametrised next-generation UART transmitter. It adds an internal baud-rate divider, a TX FIFO, run-time selectable stop-bit count, and configurable parity. Parallel words are pushed through a valid/ready handshake and serialised LSB-first onto a single line that idles high. It sits between the bus-side register block and the pad, and replaces the fixed one-bit-per-clock transmitter.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9)
FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2)
DIV_WIDTH, 16, width of the baud divider input

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
baud_div  input  DIV_WIDTH  bit period = baud_div+1 clocks
parity_enable  input  1  1 = insert parity bit after data
parity_type  input  1  0 = even, 1 = odd
two_stop_bits  input  1  0 = one stop bit, 1 = two stop bits
data_valid  input  1  push request
parallel_data  input  DATA_WIDTH  word to push
ready  output  1  FIFO not full; combinational, ready = (fifo_count != FIFO_DEPTH)
serial_data_out  output  1  registered serial line
busy  output  1  registered; 1 while a frame is in progress (state != IDLE)
fifo_count  output  $clog2(FIFO_DEPTH+1)  entries held

Behaviour:
- Reset (reset==0 at a clk edge): serial_data_out=1, busy=0, fifo_count=0, FIFO pointers=0, FSM=IDLE, baud counter=0. Applies mid-frame: the line returns high on that edge and the FIFO is flushed.
- Push: a word is written on any edge with data_valid && ready. data_valid while ready==0 is dropped silently.
- Simultaneous push and pop: count is unchanged and both operations complete.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: if FIFO is non-empty, pop on this edge. Latch the word, parity_enable, parity_type, two_stop_bits, and baud_div. Compute the parity bit: even = ^word, odd = ~^word. Clear the baud counter and go to START. Otherwise stay in IDLE.
- Config changes mid-frame have no effect until the next pop.
- Each non-IDLE state lasts exactly latched_div+1 clocks. The baud counter counts 0..latched_div; the state advances on the edge where counter==latched_div, and the counter wraps to 0.
- State transitions and line values:
  - START: line=0, then DATA.
  - DATA: line=word[idx], idx 0..DATA_WIDTH-1. idx increments per bit period. Leave after idx==DATA_WIDTH-1 to PARITY if parity enabled, else STOP1.
  - PARITY: line=parity bit, then STOP1.
  - STOP1: line=1, then STOP2 if two_stop_bits, else IDLE.
  - STOP2: line=1, then IDLE.
- Latency: with an empty FIFO and IDLE state, a word accepted at edge E0 is popped at E1. serial_data_out=0 from E1. busy=1 from E1.
- Back-to-back frames: on the edge leaving the last stop bit, the FSM enters IDLE. If the FIFO is non-empty it pops on the next edge, giving exactly one idle-high clock between frames.
- Frame length in clocks: (latched_div+1) × (1 + DATA_WIDTH + parity_enable + 1 + two_stop_bits).
- baud_div=0 is legal and gives one bit per clock.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port send_break (1 bit). While send_break=1 and the FSM is in IDLE, no pop occurs and serial_data_out=0 (registered). busy=1 during break. A frame already in progress completes normally before the break starts. Deasserting send_break returns the line high on the next edge, and FIFO draining resumes the edge after that.
- Undefined: no send_break port and no break logic.

Test Plan:
1. DATA_WIDTH=8, baud_div=3, parity off, 1 stop; push 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; busy high 40 clocks.
2. baud_div=3, parity on, push 0xA5 -> parity bit 0 with parity_type=0 and 1 with parity_type=1. With two_stop_bits=1, frame = 48 clocks ending in 8 high clocks.
3. FIFO_DEPTH=4, baud_div=7; data_valid high 6 consecutive cycles with 0x01..0x06 -> 0x01..0x05 accepted, ready=0 after the 5th accept, 0x06 dropped; 0x01..0x05 transmitted in order, 1 idle clock between frames.
4. Change baud_div from 3 to 1 mid-frame -> current frame keeps 4-clock bits; next frame uses 2-clock bits.
5. reset=0 during DATA bit 3 -> next edge serial_data_out=1, busy=0, fifo_count=0, ready=1; no residual bits after release.
6. (UART_TX_BREAK_EN) Assert send_break during frame 0x3C -> frame completes, then line low while asserted; release -> line high, queued word transmitted.
